serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_if.sv | 24 ++
 rtl/serial_addsub_fa.sv | 11 +
 rtl/serial_addsub.sv | 97 +++++++++
 tb/tb_serial_addsub.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the digit-serial adder/subtractor: FSM encoding and
// the digit-count helper used to size the counter and operand views.
package serial_addsub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int ndigits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub: start handshake, operands, results.
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, a, b, cin, sub,
    input  start_ready, sum, cout, ovf, busy, done
  );

  modport slave (
    input  start_valid, a, b, cin, sub,
    output start_ready, sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_addsub_fa.sv
// Single-bit full adder; chained DIGIT-deep inside serial_addsub.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: processes DIGIT bits per cycle LSB-first through a
// ripple of fa_cells; results are published only on the edge entering DONE.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  io
);
  localparam int ND = ndigits(WIDTH, DIGIT);
  localparam int CW = $clog2(ND + 1);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;

  logic [1:0]                 state;
  logic [CW-1:0]              cnt;
  logic                       carry;
  logic [ND-1:0][DIGIT-1:0]   a_r, b_r, res_r, res_nxt;
  logic [WIDTH-1:0]           sum_r;
  logic                       cout_r, ovf_r;
  logic [IW-1:0]              idx;
  logic [DIGIT-1:0]           s;
  logic [DIGIT:0]             c;
  logic                       last;

  assign idx  = cnt[IW-1:0];
  assign last = (cnt == CW'(ND - 1));
  assign c[0] = carry;

  genvar i;
  generate
    for (i = 0; i < DIGIT; i++) begin : g_fa
      fa_cell u_fa (
        .a    (a_r[idx][i]),
        .b    (b_r[idx][i]),
        .cin  (c[i]),
        .s    (s[i]),
        .cout (c[i+1])
      );
    end
  endgenerate

  always_comb begin
    res_nxt      = res_r;
    res_nxt[idx] = s;
  end

  // Subtraction is A + ~B + ~borrow, so the B inversion and carry seed happen at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.start_valid) begin
            a_r   <= io.a;
            b_r   <= io.sub ? ~io.b : io.b;
            carry <= io.sub ^ io.cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res_r <= res_nxt;
          carry <= c[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_r  <= res_nxt;
            cout_r <= c[DIGIT];
            ovf_r  <= c[DIGIT] ^ c[DIGIT-1];
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.start_ready = (state == S_IDLE);
  assign io.busy        = (state == S_RUN);
  assign io.done        = (state == S_DONE);
  assign io.sum         = sum_r;
  assign io.cout        = cout_r;
  assign io.ovf         = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized + directed bench for serial_addsub (DIGIT=1 and DIGIT=4 instances)
// against an integer-arithmetic reference model.
module tb_serial_addsub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) if1 ();
  serial_addsub_if #(.WIDTH(W)) if4 ();

  serial_addsub #(.WIDTH(W), .DIGIT(1)) u_dut1 (.clk(clk), .rst(rst), .io(if1));
  serial_addsub #(.WIDTH(W), .DIGIT(4)) u_dut4 (.clk(clk), .rst(rst), .io(if4));

  int n_cmp = 0;
  int n_err = 0;
  int sel   = 1;

  logic [W-1:0] g_sum;
  logic g_cout, g_ovf, g_busy, g_done, g_ready;

  always_comb begin
    if (sel == 4) begin
      g_sum = if4.sum; g_cout = if4.cout; g_ovf = if4.ovf;
      g_busy = if4.busy; g_done = if4.done; g_ready = if4.start_ready;
    end else begin
      g_sum = if1.sum; g_cout = if1.cout; g_ovf = if1.ovf;
      g_busy = if1.busy; g_done = if1.done; g_ready = if1.start_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned/signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    int ua, ub, sa, sbv, ur, sr, c;
    logic co, ov;
    logic [W-1:0] r;
    ua = int'(a); ub = int'(b); c = ci ? 1 : 0;
    sa = int'($signed(a)); sbv = int'($signed(b));
    if (!sb) begin
      ur = ua + ub + c; sr = sa + sbv + c; co = (ur >= 256);
    end else begin
      ur = ua - ub - c; sr = sa - sbv - c; co = (ua >= ub + c);
    end
    r  = ur[W-1:0];
    ov = (sr > 127) || (sr < -128);
    return {ov, co, r};
  endfunction

  task automatic drive(input int s, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    if (s == 4) begin
      if4.start_valid = v; if4.a = a; if4.b = b; if4.cin = ci; if4.sub = sb;
    end else begin
      if1.start_valid = v; if1.a = a; if1.b = b; if1.cin = ci; if1.sub = sb;
    end
  endtask

  task automatic cyc();
    @(posedge clk); @(negedge clk);
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge, idle again.
  task automatic run_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input string tag);
    int nd, edges;
    logic [W+1:0] e;
    nd = (s == 4) ? W / 4 : W;
    e  = model(a, b, ci, sb);
    sel = s;
    #1;
    chk($sformatf("%s.ready", tag), g_ready, 1);
    drive(s, 1'b1, a, b, ci, sb);
    cyc();
    drive(s, 1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    edges = 1;
    chk($sformatf("%s.busy", tag), g_busy, 1);
    while (!g_done && edges < 40) begin
      cyc();
      edges++;
    end
    chk($sformatf("%s.latency", tag), edges, nd + 1);
    chk($sformatf("%s.sum", tag), g_sum, e[W-1:0]);
    chk($sformatf("%s.cout", tag), g_cout, e[W]);
    chk($sformatf("%s.ovf", tag), g_ovf, e[W+1]);
    cyc();
    chk($sformatf("%s.done_pulse", tag), g_done, 0);
    chk($sformatf("%s.hold", tag), g_sum, e[W-1:0]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic rc, rs, saw_done;
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    int last_done, ndone;

    rst = 1'b1;
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(4, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 1; s <= 4; s += 3) begin
      sel = s; #1;
      chk($sformatf("rst%0d.sum", s), g_sum, 0);
      chk($sformatf("rst%0d.done", s), g_done, 0);
      chk($sformatf("rst%0d.busy", s), g_busy, 0);
      chk($sformatf("rst%0d.ready", s), g_ready, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Directed corner cases
    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, "posovf");
    run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, "subneg");
    run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, "subovf");
    run_op(1, 8'h00, 8'hFF, 1'b1, 1'b1, "subborrow");
    run_op(4, 8'h3C, 8'hC4, 1'b1, 1'b0, "d4add");
    run_op(4, 8'h80, 8'h80, 1'b0, 1'b0, "d4negovf");

    for (int k = 0; k < 40; k++)
      run_op(1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("r1_%0d", k));
    for (int k = 0; k < 20; k++)
      run_op(4, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("r4_%0d", k));

    // Reset on the third RUN cycle aborts with no done pulse
    sel = 1;
    drive(1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    cyc();
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("abort.busy", g_busy, 0);
    chk("abort.done", g_done, 0);
    chk("abort.sum", g_sum, 0);
    chk("abort.cout", g_cout, 0);
    chk("abort.ovf", g_ovf, 0);
    chk("abort.ready", g_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (g_done) saw_done = 1'b1;
    end
    chk("abort.no_done", saw_done, 0);
    run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, "post_abort");

    // start_valid held high with operands changing every cycle
    sel = 1;
    last_done = -1;
    ndone = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (g_done) begin
        if (q.size() == 0) chk("hold.spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk($sformatf("hold%0d.sum", ndone), g_sum, e[W-1:0]);
          chk($sformatf("hold%0d.cout", ndone), g_cout, e[W]);
          chk($sformatf("hold%0d.ovf", ndone), g_ovf, e[W+1]);
        end
        if (last_done >= 0) chk($sformatf("hold%0d.period", ndone), c - last_done, W + 2);
        last_done = c;
        ndone++;
      end
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      drive(1, 1'b1, ra, rb, rc, rs);
      if (g_ready) q.push_back(model(ra, rb, rc, rs));
      cyc();
    end
    drive(1, 1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      if (g_done) begin
        e = q.pop_front();
        chk("hold_tail.sum", g_sum, e[W-1:0]);
        ndone++;
      end
      drive(1, 1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      cyc();
    end
    chk("hold.drained", q.size(), 0);
    chk("hold.count_ok", (ndone >= 6) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
